mod_swapchain_ctl: RTL and testbench

MOD_SWAPCHAIN_CTL -- requirements
Module: mod_swapchain_ctl

---
 rtl/mod_swapchain_ctl.sv | 190 +++++++++++++++++++
 tb/tb_mod_swapchain_ctl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_swapchain_ctl.sv
// ---------------------------------------------------------------------------
// mod_swapchain_ctl
//
// Double-buffered modulation segment controller. A playback sampler runs the
// active segment while a request for the next segment is armed here; the swap
// happens when the armed condition fires. The swap can be immediate, at a
// system-time deadline, on a GPIO rising edge, or at the next sample-index
// wrap. The block also counts completed loops of the active segment and stops
// playback after a finite repetition count.
//
// Ports
//   clk              in   1   system clock, rising edge
//   rst              in   1   asynchronous active-high reset
//   update           in   1   pulse: new request on the inputs below
//   req_rd_segment   in   1   segment requested for playback
//   transition_mode  in   8   0x00 sync-idx, 0x01 sys-time, 0x02 gpio,
//                             0xFF immediate
//   transition_value in  64   sys-time deadline, or gpio pin in [1:0]
//   rep0, rep1       in  32   loop count per segment (all ones = infinite)
//   sys_time         in  64   free-running system time
//   gpio_in          in   4   asynchronous trigger pins
//   idx_wrap         in   1   pulse: sampler index wrapped to 0
//   segment          out  1   active segment
//   swap             out  1   pulse in the cycle segment changes/restarts
//   stop             out  1   active segment finished its repetitions
//   pending          out  1   a request is armed
//   loop_cnt         out 32   completed loops of the active segment
//   err              out  1   pulse: update carried an unsupported mode
// ---------------------------------------------------------------------------
module mod_swapchain_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic        req_rd_segment,
  input  logic [7:0]  transition_mode,
  input  logic [63:0] transition_value,
  input  logic [31:0] rep0,
  input  logic [31:0] rep1,
  input  logic [63:0] sys_time,
  input  logic [3:0]  gpio_in,
  input  logic        idx_wrap,
  output logic        segment,
  output logic        swap,
  output logic        stop,
  output logic        pending,
  output logic [31:0] loop_cnt,
  output logic        err
);

  localparam logic [7:0]  MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0]  MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0]  MODE_GPIO      = 8'h02;
  localparam logic [7:0]  MODE_IMMEDIATE = 8'hFF;
  localparam logic [31:0] REP_INFINITE   = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      state_r;

  // Armed request, captured on a supported update.
  logic        seg_l_r;
  logic [7:0]  mode_l_r;
  logic [63:0] value_l_r;
  logic [31:0] rep0_l_r;
  logic [31:0] rep1_l_r;

  // Repetition limit of the segment currently playing.
  logic [31:0] act_rep_r;

  // Two-flop synchronizer plus one history stage for edge detection.
  logic [3:0]  sync1_r;
  logic [3:0]  sync2_r;
  logic [3:0]  sync3_r;

  logic        mode_ok_s;
  logic        gpio_rise_s;
  logic        trigger_s;
  logic        rep_done_s;

  // Synchronize the GPIO pins; they are sampled continuously so that a pin
  // already high when a request arms does not look like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 4'd0;
      sync2_r <= 4'd0;
      sync3_r <= 4'd0;
    end else begin
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Classify the incoming transition mode.
  always_comb begin
    mode_ok_s = 1'b0;
    case (transition_mode)
      MODE_SYNC_IDX:  mode_ok_s = 1'b1;
      MODE_SYS_TIME:  mode_ok_s = 1'b1;
      MODE_GPIO:      mode_ok_s = 1'b1;
      MODE_IMMEDIATE: mode_ok_s = 1'b1;
      default:        mode_ok_s = 1'b0;
    endcase
  end

  // Rising edge on the GPIO pin selected by the armed request.
  always_comb begin
    gpio_rise_s = sync2_r[value_l_r[1:0]] & ~sync3_r[value_l_r[1:0]];
  end

  // Swap condition; only meaningful while a request is armed. A stopped
  // segment never wraps again, so sync-idx also fires on stop.
  always_comb begin
    trigger_s = 1'b0;
    if (state_r == ST_WAIT) begin
      case (mode_l_r)
        MODE_IMMEDIATE: trigger_s = 1'b1;
        MODE_SYS_TIME:  trigger_s = (sys_time >= value_l_r);
        MODE_GPIO:      trigger_s = gpio_rise_s;
        MODE_SYNC_IDX:  trigger_s = idx_wrap | stop;
        default:        trigger_s = 1'b0;
      endcase
    end else begin
      trigger_s = 1'b0;
    end
  end

  // A wrap at this count ends a finite segment.
  always_comb begin
    rep_done_s = (act_rep_r != REP_INFINITE) && (loop_cnt == act_rep_r);
  end

  // Request/swap FSM with loop counting and all registered outputs. The swap
  // uses the previously armed request while a coincident update re-arms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RUN;
      pending   <= 1'b0;
      segment   <= 1'b0;
      swap      <= 1'b0;
      stop      <= 1'b0;
      loop_cnt  <= 32'd0;
      err       <= 1'b0;
      act_rep_r <= REP_INFINITE;
      seg_l_r   <= 1'b0;
      mode_l_r  <= 8'h00;
      value_l_r <= 64'd0;
      rep0_l_r  <= 32'd0;
      rep1_l_r  <= 32'd0;
    end else begin
      swap <= 1'b0;
      err  <= 1'b0;

      if (trigger_s) begin
        // Swap wins over a coincident wrap: the wrap is not counted.
        segment   <= seg_l_r;
        swap      <= 1'b1;
        loop_cnt  <= 32'd0;
        stop      <= 1'b0;
        act_rep_r <= seg_l_r ? rep1_l_r : rep0_l_r;
        state_r   <= ST_RUN;
        pending   <= 1'b0;
      end else if (idx_wrap && !stop) begin
        if (rep_done_s) begin
          stop <= 1'b1;
        end else begin
          loop_cnt <= loop_cnt + 32'd1;
        end
      end

      if (update) begin
        if (mode_ok_s) begin
          seg_l_r   <= req_rd_segment;
          mode_l_r  <= transition_mode;
          value_l_r <= transition_value;
          rep0_l_r  <= rep0;
          rep1_l_r  <= rep1;
          state_r   <= ST_WAIT;
          pending   <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_swapchain_ctl.sv
module tb_mod_swapchain_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        update;
  logic        req_rd_segment;
  logic [7:0]  transition_mode;
  logic [63:0] transition_value;
  logic [31:0] rep0;
  logic [31:0] rep1;
  logic [63:0] sys_time;
  logic [3:0]  gpio_in;
  logic        idx_wrap;
  logic        segment;
  logic        swap;
  logic        stop;
  logic        pending;
  logic [31:0] loop_cnt;
  logic        err;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic        m_seg, m_swap, m_stop, m_pend, m_err;
  logic [31:0] m_loop, m_rep;
  logic        r_seg;
  logic [7:0]  r_mode;
  logic [63:0] r_val;
  logic [31:0] r_rep0, r_rep1;
  logic [3:0]  ghist[$];   // pin values sampled at the most recent edges

  always #5 clk = ~clk;

  mod_swapchain_ctl dut (
    .clk(clk), .rst(rst), .update(update), .req_rd_segment(req_rd_segment),
    .transition_mode(transition_mode), .transition_value(transition_value),
    .rep0(rep0), .rep1(rep1), .sys_time(sys_time), .gpio_in(gpio_in),
    .idx_wrap(idx_wrap), .segment(segment), .swap(swap), .stop(stop),
    .pending(pending), .loop_cnt(loop_cnt), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".segment"},  {63'd0, segment}, {63'd0, m_seg});
    chk({where, ".swap"},     {63'd0, swap},    {63'd0, m_swap});
    chk({where, ".stop"},     {63'd0, stop},    {63'd0, m_stop});
    chk({where, ".pending"},  {63'd0, pending}, {63'd0, m_pend});
    chk({where, ".loop_cnt"}, {32'd0, loop_cnt}, {32'd0, m_loop});
    chk({where, ".err"},      {63'd0, err},     {63'd0, m_err});
  endtask

  task automatic model_reset();
    m_seg = 1'b0; m_swap = 1'b0; m_stop = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    m_loop = 32'd0; m_rep = 32'hFFFF_FFFF;
    r_seg = 1'b0; r_mode = 8'h00; r_val = 64'd0; r_rep0 = 32'd0; r_rep1 = 32'd0;
    ghist = {4'd0, 4'd0, 4'd0};
  endtask

  // One clock edge of the behavioural rules, using the inputs held at the edge.
  task automatic model_edge();
    logic       trig;
    logic [3:0] newer, older;
    trig = 1'b0;
    if (m_pend) begin
      if (r_mode == 8'hFF) trig = 1'b1;
      else if (r_mode == 8'h01) trig = (sys_time >= r_val);
      else if (r_mode == 8'h02) begin
        // Pin rose between the samples taken two and three edges ago.
        newer = ghist[ghist.size() - 2];
        older = ghist[ghist.size() - 3];
        trig = newer[r_val[1:0]] && !older[r_val[1:0]];
      end
      else if (r_mode == 8'h00) trig = idx_wrap || m_stop;
    end
    m_swap = 1'b0;
    m_err  = 1'b0;
    if (trig) begin
      m_seg = r_seg; m_swap = 1'b1; m_loop = 32'd0; m_stop = 1'b0;
      m_rep = r_seg ? r_rep1 : r_rep0; m_pend = 1'b0;
    end else if (idx_wrap && !m_stop) begin
      if (m_rep != 32'hFFFF_FFFF && m_loop == m_rep) m_stop = 1'b1;
      else m_loop = m_loop + 32'd1;
    end
    if (update) begin
      if (transition_mode == 8'h00 || transition_mode == 8'h01 ||
          transition_mode == 8'h02 || transition_mode == 8'hFF) begin
        r_seg = req_rd_segment; r_mode = transition_mode; r_val = transition_value;
        r_rep0 = rep0; r_rep1 = rep1; m_pend = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    ghist.push_back(gpio_in);
    if (ghist.size() > 3) void'(ghist.pop_front());
  endtask

  // Advance one clock, check every output, then drop the pulse inputs.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all("cycle");
    update   = 1'b0;
    idx_wrap = 1'b0;
  endtask

  task automatic arm(input logic seg, input logic [7:0] mode, input logic [63:0] val,
                     input logic [31:0] r0, input logic [31:0] r1);
    update = 1'b1; req_rd_segment = seg; transition_mode = mode;
    transition_value = val; rep0 = r0; rep1 = r1;
    cyc();
  endtask

  initial begin
    int          swap_at;
    logic [63:0] swap_time;
    int          exp_loop[5] = '{1, 2, 2, 2, 2};
    int          exp_stop[5] = '{0, 0, 1, 1, 1};

    rst = 1'b1; update = 1'b0; req_rd_segment = 1'b0; transition_mode = 8'h00;
    transition_value = 64'd0; rep0 = 32'd0; rep1 = 32'd0; sys_time = 64'd0;
    gpio_in = 4'd0; idx_wrap = 1'b0;
    #12;
    model_reset();
    check_all("reset");
    rst = 1'b0;
    cyc();

    // Immediate swap to segment 1.
    arm(1'b1, 8'hFF, 64'd0, 32'd0, 32'hFFFF_FFFF);
    chk("imm_pending", {63'd0, pending}, 64'd1);
    cyc();
    chk("imm_swap", {63'd0, swap}, 64'd1);
    chk("imm_segment", {63'd0, segment}, 64'd1);
    cyc();

    // Finite repetition: rep1 = 2, five wraps.
    arm(1'b1, 8'hFF, 64'd0, 32'd0, 32'd2);
    cyc();
    for (int i = 0; i < 5; i++) begin
      idx_wrap = 1'b1;
      cyc();
      chk("rep_loop", {32'd0, loop_cnt}, 64'(exp_loop[i]));
      chk("rep_stop", {63'd0, stop}, 64'(exp_stop[i]));
      cyc();
    end

    // Sync-idx armed while stopped swaps on the next edge.
    arm(1'b0, 8'h00, 64'd0, 32'd5, 32'd5);
    cyc();
    chk("sync_stop_swap", {63'd0, swap}, 64'd1);
    chk("sync_stop_clear", {63'd0, stop}, 64'd0);

    // Deadline 1000 with time stepping by 1.
    sys_time = 64'd990;
    arm(1'b1, 8'h01, 64'd1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    swap_time = 64'd0;
    for (int k = 0; k < 20; k++) begin
      sys_time = 64'd991 + 64'(k);
      cyc();
      if (swap) swap_time = sys_time;
    end
    chk("deadline_time", swap_time, 64'd1000);
    // Deadline already past.
    sys_time = 64'd900;
    arm(1'b0, 8'h01, 64'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc();
    chk("past_deadline_swap", {63'd0, swap}, 64'd1);

    // Wrap coincident with sync-idx trigger: loop count restarts at 0.
    idx_wrap = 1'b1; cyc();
    idx_wrap = 1'b1; cyc();
    arm(1'b1, 8'h00, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idx_wrap = 1'b1;
    cyc();
    chk("wrap_swap", {63'd0, swap}, 64'd1);
    chk("wrap_loop_zero", {32'd0, loop_cnt}, 64'd0);

    // Unsupported mode.
    arm(1'b0, 8'h07, 64'd0, 32'd0, 32'd0);
    chk("bad_mode_err", {63'd0, err}, 64'd1);
    chk("bad_mode_pending", {63'd0, pending}, 64'd0);
    cyc();

    // Second update in wait replaces the first.
    arm(1'b1, 8'h01, 64'hFFFF_FFFF_0000_0000, 32'd0, 32'd0);
    arm(1'b0, 8'hFF, 64'd0, 32'd0, 32'd0);
    cyc();
    chk("replace_segment", {63'd0, segment}, 64'd0);
    chk("replace_swap", {63'd0, swap}, 64'd1);

    // GPIO edge while running is ignored.
    cyc();
    gpio_in = 4'b0100;
    repeat (4) cyc();
    arm(1'b1, 8'h02, 64'd2, 32'd0, 32'd0);
    repeat (4) cyc();
    chk("gpio_run_ignored", {63'd0, pending}, 64'd1);
    // GPIO pin 2 edge in wait: swap three edges later.
    gpio_in = 4'b0000;
    repeat (3) cyc();
    gpio_in = 4'b0100;
    swap_at = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (swap && swap_at == 0) swap_at = k;
    end
    chk("gpio_latency", 64'(swap_at), 64'd3);

    // Reset in wait discards the request.
    arm(1'b0, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 32'd0);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_wait_reset");
    #2;
    rst = 1'b0;
    cyc();
    cyc();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      update = ($urandom % 6) == 0;
      req_rd_segment = 1'($urandom);
      case ($urandom % 5)
        0: transition_mode = 8'h00;
        1: transition_mode = 8'h01;
        2: transition_mode = 8'h02;
        3: transition_mode = 8'hFF;
        default: transition_mode = 8'($urandom);
      endcase
      transition_value = sys_time + 64'($urandom_range(0, 30)) - 64'd8;
      rep0 = (($urandom % 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
      rep1 = (($urandom % 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
      idx_wrap = ($urandom % 3) == 0;
      if (($urandom % 5) == 0) gpio_in = 4'($urandom);
      sys_time = sys_time + 64'($urandom_range(0, 2));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
